// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed via magnitude + fix-up.
// Fixed latency of WIDTH+3 cycles from START acceptance to the DONE pulse.
module mult_seq_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             SIGNED_MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {StIdle, StSetup, StIter, StSign, StDone} state_e;

   state_e             state_q;
   logic               signed_q;
   logic               neg_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CntW-1:0]    cnt_q;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] result;

   // Negating the most-negative value yields 2^(WIDTH-1), which fits unsigned.
   always_comb begin
      mag_a  = a_q;
      mag_b  = b_q;
      result = acc_q;
      if (signed_q && a_q[WIDTH-1]) mag_a = -a_q;
      if (signed_q && b_q[WIDTH-1]) mag_b = -b_q;
      if (neg_q) result = -acc_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         signed_q <= 1'b0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         HI       <= '0;
         LO       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  a_q      <= A;
                  b_q      <= B;
                  signed_q <= SIGNED_MODE;
                  BUSY     <= 1'b1;
                  state_q  <= StSetup;
               end
            end
            StSetup: begin
               // A zero product is never negated.
               neg_q   <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (|a_q) & (|b_q);
               mcand_q <= {{WIDTH{1'b0}}, mag_a};
               b_q     <= mag_b;
               acc_q   <= '0;
               cnt_q   <= '0;
               state_q <= StIter;
            end
            StIter: begin
               // mcand_q holds magA << cnt_q, so no barrel shifter is needed.
               if (b_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q <= mcand_q << 1;
               b_q     <= b_q >> 1;
               cnt_q   <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) state_q <= StSign;
            end
            StSign: begin
               HI      <= result[2*WIDTH-1:WIDTH];
               LO      <= result[WIDTH-1:0];
               DONE    <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               DONE    <= 1'b0;
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
